stream_out_vector_ping_pong: RTL and testbench

//  Vector-to-stream serializer: accepts an N-element vector in one beat, emits
//  the elements one per cycle, element 0 first. This is the transmit-side

---
 rtl/stream_out_vector_ping_pong_pkg.sv | 17 +
 rtl/stream_out_vector_ping_pong_if.sv | 26 ++
 rtl/stream_out_vector_ping_pong.sv | 75 +++++++
 tb/tb_stream_out_vector_ping_pong.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_out_vector_ping_pong_pkg.sv
// Shared definitions for the vector-to-stream ping/pong serializer.
// Holds default geometry and the bank selector type.
package stream_out_vector_ping_pong_pkg;

    localparam int DEF_BITS = 8;
    localparam int DEF_N    = 3;

    typedef enum logic {
        BANK_PING = 1'b0,
        BANK_PONG = 1'b1
    } bank_e;

    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK_PING) ? BANK_PONG : BANK_PING;
    endfunction

endpackage

// File: rtl/stream_out_vector_ping_pong_if.sv
// Vector-in / element-out handshake bundle for the ping/pong serializer.
// The slave modport is the serializer's view; master is the surrounding logic.
interface stream_out_vector_ping_pong_if
    import stream_out_vector_ping_pong_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int N    = DEF_N
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0][BITS-1:0]   a;
    logic                     out_valid;
    logic                     out_ready;
    logic [BITS-1:0]          c;
    logic                     out_last;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, c, out_last
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, c, out_last
    );
endinterface

// File: rtl/stream_out_vector_ping_pong.sv
// Two-bank vector-to-stream serializer: one bank loads while the other drains,
// emitting element 0 first, one element per accepted output beat.
module stream_out_vector_ping_pong
    import stream_out_vector_ping_pong_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int N    = DEF_N
) (
    input  logic                          clk,
    input  logic                          reset,
    stream_out_vector_ping_pong_if.slave  bus
);

    localparam int             CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [1:0][N-1:0][BITS-1:0] bank;
    logic [1:0]                  full;
    bank_e                       wr_sel;
    bank_e                       rd_sel;
    logic [CW-1:0]               rd_count;

    logic                        accept;
    logic                        xfer;
    logic                        drain;
    logic [BITS-1:0]             elem;

    // Element mux by compare so N=1 (single-entry bank) needs no special index width.
    always_comb begin
        elem = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_count == CW'(i)) elem = bank[rd_sel][i];
        end
    end

    assign accept = bus.in_valid && !full[wr_sel];
    assign xfer   = full[rd_sel] && bus.out_ready;
    assign drain  = xfer && (rd_count == LAST);

    assign bus.in_ready  = !full[wr_sel];
    assign bus.out_valid = full[rd_sel];
    assign bus.c         = full[rd_sel] ? elem : '0;
    assign bus.out_last  = full[rd_sel] && (rd_count == LAST);

    // Accept and drain never target the same bank in one cycle: accept needs the
    // write bank empty, drain needs the read bank full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank     <= '0;
            full     <= '0;
            wr_sel   <= BANK_PING;
            rd_sel   <= BANK_PING;
            rd_count <= '0;
        end else begin
            if (accept) begin
                bank[wr_sel] <= bus.a;
                full[wr_sel] <= 1'b1;
                wr_sel       <= other_bank(wr_sel);
            end
            if (drain) begin
                rd_count     <= '0;
                full[rd_sel] <= 1'b0;
                rd_sel       <= other_bank(rd_sel);
            end else if (xfer) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    // A presented element must not change or vanish while stalled.
    a_hold : assert property (@(posedge clk) disable iff (reset)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.c) && $stable(bus.out_last)));

endmodule

// File: tb/tb_stream_out_vector_ping_pong.sv
// Bench for the ping/pong serializer: directed table for N=3, async reset
// sequence, and randomized runs for N=1,3,8 against an element-queue model.
module tb_stream_out_vector_ping_pong;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Directed DUT, N=3
    stream_out_vector_ping_pong_if #(.BITS(8), .N(3)) d3if ();
    stream_out_vector_ping_pong #(.BITS(8), .N(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (d3if.slave)
    );

    typedef struct {
        logic            iv;
        logic [2:0][7:0] a;
        logic            ordy;
        logic            eir;
        logic            eov;
        logic [7:0]      ec;
        logic            el;
    } row_t;

    row_t tbl[$];

    function automatic logic [2:0][7:0] v3(input logic [7:0] e0, e1, e2);
        logic [2:0][7:0] v;
        v[0] = e0; v[1] = e1; v[2] = e2;
        return v;
    endfunction

    function automatic row_t mk(input logic iv, input logic [2:0][7:0] a, input logic ordy,
                                input logic eir, input logic eov, input logic [7:0] ec,
                                input logic el);
        row_t r;
        r.iv = iv; r.a = a; r.ordy = ordy;
        r.eir = eir; r.eov = eov; r.ec = ec; r.el = el;
        return r;
    endfunction

    task automatic chk_out(input string tag, input logic eir, input logic eov,
                           input logic [7:0] ec, input logic el);
        chk({tag, " in_ready"},  32'(d3if.in_ready),  32'(eir));
        chk({tag, " out_valid"}, 32'(d3if.out_valid), 32'(eov));
        chk({tag, " c"},         32'(d3if.c),         32'(ec));
        chk({tag, " out_last"},  32'(d3if.out_last),  32'(el));
    endtask

    // Randomized instances, one per N
    logic       rand_go = 1'b0;
    logic [2:0] rand_done = 3'b000;

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int NG   = (g == 0) ? 1 : (g == 1) ? 3 : 8;
        localparam int NVEC = (g == 2) ? 200 : 400;

        stream_out_vector_ping_pong_if #(.BITS(8), .N(NG)) rif ();
        stream_out_vector_ping_pong #(.BITS(8), .N(NG)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (rif.slave)
        );

        initial begin
            logic [7:0]          q[$];
            logic [NG-1:0][7:0]  av;
            logic                pending;
            logic                ov, ir, acc, xf;
            int                  nvec, sent, accepted, lasts, cyc;
            string               tag;
            tag = $sformatf("rand N=%0d", NG);
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b0;
            rif.a         = '0;
            av = '0; pending = 1'b0;
            nvec = 0; sent = 0; accepted = 0; lasts = 0; cyc = 0;
            wait (rand_go);
            while ((accepted < NVEC || nvec > 0 || pending) && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                ov = rif.out_valid;
                ir = rif.in_ready;
                // Model: up to two whole vectors queued, elements leave in order.
                chk({tag, " out_valid"}, 32'(ov), 32'(nvec > 0));
                chk({tag, " in_ready"},  32'(ir), 32'(nvec < 2));
                if (nvec > 0) begin
                    chk({tag, " c"},        32'(rif.c),        32'(q[0]));
                    chk({tag, " out_last"}, 32'(rif.out_last), 32'(sent == NG - 1));
                end else begin
                    chk({tag, " idle c"},    32'(rif.c),        32'(0));
                    chk({tag, " idle last"}, 32'(rif.out_last), 32'(0));
                end
                if (!pending && accepted < NVEC && ($urandom % 4) != 0) begin
                    for (int i = 0; i < NG; i++) av[i] = 8'($urandom);
                    pending = 1'b1;
                end
                rif.in_valid  = pending;
                rif.a         = pending ? av : NG*8'($urandom);
                rif.out_ready = (($urandom % 3) != 0);
                acc = pending && ir;
                xf  = ov && rif.out_ready;
                if (xf) begin
                    void'(q.pop_front());
                    sent++;
                    if (sent == NG) begin
                        sent = 0;
                        nvec--;
                        lasts++;
                    end
                end
                if (acc) begin
                    for (int i = 0; i < NG; i++) q.push_back(av[i]);
                    nvec++;
                    accepted++;
                    pending = 1'b0;
                end
            end
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b0;
            chk({tag, " finished in budget"}, 32'(cyc < 40000), 32'(1));
            chk({tag, " last count"},         32'(lasts),        32'(NVEC));
            chk({tag, " queue empty"},        32'(q.size()),     32'(0));
            rand_done[g] = 1'b1;
        end
    end

    initial begin
        d3if.in_valid  = 1'b0;
        d3if.out_ready = 1'b0;
        d3if.a         = '0;

        // Single vector
        tbl.push_back(mk(1, v3(8'h11, 8'h22, 8'h33), 1, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, v3(0, 0, 0),             1, 1, 1, 8'h11, 0));
        tbl.push_back(mk(0, v3(0, 0, 0),             1, 1, 1, 8'h22, 0));
        tbl.push_back(mk(0, v3(0, 0, 0),             1, 1, 1, 8'h33, 1));
        tbl.push_back(mk(0, v3(0, 0, 0),             1, 1, 0, 8'h00, 0));
        // Back-to-back vectors, no bubble
        tbl.push_back(mk(1, v3(1, 2, 3), 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, v3(4, 5, 6), 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 0, 1, 3, 1));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 1, 1, 4, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 0, 1, 5, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 0, 1, 6, 1));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 7, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 8, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 9, 1));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 0, 0, 0));
        // Backpressure on element 2 for five cycles
        tbl.push_back(mk(1, v3(1, 2, 3), 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, v3(4, 5, 6), 1, 1, 1, 1, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, v3(7, 8, 9), 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 0, 1, 3, 1));
        tbl.push_back(mk(1, v3(7, 8, 9), 1, 1, 1, 4, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 0, 1, 5, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 0, 1, 6, 1));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 7, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 8, 0));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 1, 9, 1));
        tbl.push_back(mk(0, v3(0, 0, 0), 1, 1, 0, 0, 0));

        #12;
        chk_out("reset", 1, 0, 8'h00, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            d3if.in_valid  = tbl[i].iv;
            d3if.a         = tbl[i].a;
            d3if.out_ready = tbl[i].ordy;
            chk_out($sformatf("row%0d", i), tbl[i].eir, tbl[i].eov, tbl[i].ec, tbl[i].el);
        end

        // Reset mid-vector with a second vector buffered
        @(negedge clk);
        d3if.in_valid = 1'b1; d3if.a = v3(8'hA0, 8'hA1, 8'hA2); d3if.out_ready = 1'b1;
        @(negedge clk);
        d3if.a = v3(8'hB0, 8'hB1, 8'hB2);
        @(negedge clk);
        d3if.in_valid = 1'b0;
        chk_out("pre-reset", 1'b0, 1'b1, 8'hA1, 1'b0);
        #2 reset = 1'b1;
        #1 chk_out("async reset", 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        d3if.in_valid = 1'b1; d3if.a = v3(8'hC0, 8'hC1, 8'hC2);
        @(negedge clk);
        d3if.in_valid = 1'b0;
        chk_out("post-reset e0", 1'b1, 1'b1, 8'hC0, 1'b0);
        @(negedge clk);
        chk_out("post-reset e1", 1'b1, 1'b1, 8'hC1, 1'b0);
        @(negedge clk);
        chk_out("post-reset e2", 1'b1, 1'b1, 8'hC2, 1'b1);
        @(negedge clk);
        chk_out("post-reset empty", 1'b1, 1'b0, 8'h00, 1'b0);
        d3if.out_ready = 1'b0;

        rand_go = 1'b1;
        for (int k = 0; k < 60000 && rand_done != 3'b111; k++) @(negedge clk);
        chk("random runs complete", 32'(rand_done), 32'(3'b111));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
